sum_accumulator: RTL and testbench

//  Downstream stage of the 8-bit adder (sum, co). Accepts a stream of adder results {co,sum} over a

---
 rtl/sum_accumulator.sv | 116 +++++++++++
 tb/tb_sum_accumulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Downstream stage of the 8-bit adder. Accepts adder results {co,sum} over a
//   valid/ready handshake, sums COUNT consecutive results into an ACC_W-bit
//   total, then presents the total and a sticky wrap flag on an output
//   handshake before starting the next block.
//
// Parameters
//   IN_W   adder sum width; each operand is IN_W+1 bits ({co,sum})
//   ACC_W  accumulator / total width (>= IN_W+1)
//   COUNT  samples per block (>= 1)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   upstream sample valid
//   in_ready   stage can accept a sample (low while holding or in reset)
//   in_sum     adder sum
//   in_co      adder carry-out, operand MSB
//   out_valid  block total available
//   out_ready  downstream accepts the total
//   out_total  accumulated total (meaningful while out_valid=1)
//   out_ovf    sticky: total wrapped past 2^ACC_W during this block
//   busy       block partially accumulated or total being held
module sum_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_accept;
  logic             release_total;
  logic [ACC_W:0]   op;
  logic [ACC_W:0]   sum_ext;

  // Unsigned add with the carry out of bit ACC_W-1 returned in the MSB, so the
  // caller can keep the wrapped value and the wrap flag separately.
  function automatic logic [ACC_W:0] wrap_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W:0]   b);
    return {1'b0, a} + b;
  endfunction

  // {co,sum} is an unsigned IN_W+1 bit value; ACC_W >= IN_W+1 keeps the
  // replication count positive.
  assign op          = {{(ACC_W - IN_W){1'b0}}, in_co, in_sum};
  assign sum_ext     = wrap_add(acc, op);

  // in_ready depends only on state and reset, never on in_valid.
  assign in_ready      = (state == ACC) && !reset;
  assign accept        = in_valid && in_ready;
  assign last_accept   = accept && (cnt == CNT_LAST);
  assign release_total = (state == HOLD) && out_ready;

  assign out_valid = (state == HOLD);
  assign out_total = acc;
  assign out_ovf   = ovf;
  assign busy      = (cnt != '0) || (state == HOLD);

  always_ff @(posedge clock) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last_accept)   state_nxt = HOLD;
      HOLD:    if (release_total) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum_ext[ACC_W-1:0];
      ovf <= ovf | sum_ext[ACC_W];
      cnt <= last_accept ? '0 : cnt + CNT_ONE;
    end else if (release_total) begin
      // Next block starts from a clean total; cnt is already 0 here.
      acc <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Instance A: COUNT=4, ACC_W=12
  logic        a_in_valid = 1'b0, a_in_ready, a_in_co = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic [7:0]  a_in_sum = '0;
  logic [11:0] a_out_total;
  logic        a_out_ovf, a_busy;
  // Instance B: COUNT=4, ACC_W=10
  logic        b_in_valid = 1'b0, b_in_ready, b_in_co = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic [7:0]  b_in_sum = '0;
  logic [9:0]  b_out_total;
  logic        b_out_ovf, b_busy;
  // Instance C: COUNT=1, ACC_W=12
  logic        c_in_valid = 1'b0, c_in_ready, c_in_co = 1'b0, c_out_valid, c_out_ready = 1'b0;
  logic [7:0]  c_in_sum = '0;
  logic [11:0] c_out_total;
  logic        c_out_ovf, c_busy;

  int checks = 0;
  int errors = 0;

  sum_accumulator #(.IN_W(8), .ACC_W(12), .COUNT(4)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sum(a_in_sum), .in_co(a_in_co), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_total(a_out_total), .out_ovf(a_out_ovf), .busy(a_busy));

  sum_accumulator #(.IN_W(8), .ACC_W(10), .COUNT(4)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .in_co(b_in_co), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_total(b_out_total), .out_ovf(b_out_ovf), .busy(b_busy));

  sum_accumulator #(.IN_W(8), .ACC_W(12), .COUNT(1)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sum(c_in_sum), .in_co(c_in_co), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_total(c_out_total), .out_ovf(c_out_ovf), .busy(c_busy));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One sample into A, presented for exactly one cycle.
  task automatic send_a(input logic [7:0] s, input logic c);
    a_in_valid = 1'b1; a_in_sum = s; a_in_co = c;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL send_a_in_ready got %b want 1", a_in_ready);
    end
    tick();
    a_in_valid = 1'b0; a_in_sum = 8'h00; a_in_co = 1'b0;
  endtask

  // Handshake A's held total and confirm it returns to an empty ACC state.
  task automatic drain_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_total !== 12'h000) begin
      errors++;
      $display("FAIL drain_a got valid=%b ready=%b busy=%b total=%h want 0 1 0 000",
               a_out_valid, a_in_ready, a_busy, a_out_total);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low got %b want 0", a_in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_total !== 12'h000 || a_out_ovf !== 1'b0 ||
        a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got valid=%b total=%h ovf=%b busy=%b ready=%b want 0 000 0 0 1",
               a_out_valid, a_out_total, a_out_ovf, a_busy, a_in_ready);
    end
    checks++;
    if (b_in_ready !== 1'b1 || c_in_ready !== 1'b1 || b_busy !== 1'b0 || c_busy !== 1'b0) begin
      errors++; $display("FAIL reset_other_inst got b_ready=%b c_ready=%b want 1 1", b_in_ready, c_in_ready);
    end
  endtask

  task automatic test_basic();
    send_a(8'h10, 1'b0);
    send_a(8'h20, 1'b0);
    send_a(8'h30, 1'b0);
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL basic_before_last got valid=%b busy=%b want 0 1", a_out_valid, a_busy);
    end
    send_a(8'h40, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_total !== 12'h0A0 || a_out_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_total got valid=%b total=%h ovf=%b ready=%b want 1 0a0 0 0",
               a_out_valid, a_out_total, a_out_ovf, a_in_ready);
    end
    drain_a();
  endtask

  task automatic test_carry();
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_sum = 8'hFF; a_in_co = 1'b1;
      b_in_valid = 1'b1; b_in_sum = 8'hFF; b_in_co = 1'b1;
      tick();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_total !== 12'h7FC || a_out_ovf !== 1'b0) begin
      errors++; $display("FAIL carry_acc12 got valid=%b total=%h ovf=%b want 1 7fc 0",
                         a_out_valid, a_out_total, a_out_ovf);
    end
    checks++;
    if (b_out_valid !== 1'b1 || b_out_total !== 10'h3FC || b_out_ovf !== 1'b1) begin
      errors++; $display("FAIL carry_acc10 got valid=%b total=%h ovf=%b want 1 3fc 1",
                         b_out_valid, b_out_total, b_out_ovf);
    end
    b_out_ready = 1'b1;
    drain_a();
    b_out_ready = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0 || b_out_ovf !== 1'b0 || b_out_total !== 10'h000) begin
      errors++; $display("FAIL carry_acc10_clear got valid=%b ovf=%b total=%h want 0 0 000",
                         b_out_valid, b_out_ovf, b_out_total);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] vals [4];
    int         gaps [4];
    vals = '{8'h10, 8'h20, 8'h30, 8'h40};
    gaps = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin
          errors++; $display("FAIL gaps_busy got busy=%b valid=%b want 1 0", a_busy, a_out_valid);
        end
      end
      send_a(vals[i], 1'b0);
    end
    checks++;
    if (a_out_valid !== 1'b1 || a_out_total !== 12'h0A0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL gaps_total got valid=%b total=%h busy=%b want 1 0a0 1",
                         a_out_valid, a_out_total, a_busy);
    end
    drain_a();
  endtask

  task automatic test_backpressure();
    send_a(8'h10, 1'b0);
    send_a(8'h20, 1'b0);
    send_a(8'h30, 1'b0);
    send_a(8'h40, 1'b0);
    a_in_valid = 1'b1; a_in_sum = 8'hFF; a_in_co = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_total !== 12'h0A0 || a_out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold got ready=%b valid=%b total=%h ovf=%b want 0 1 0a0 0",
                 a_in_ready, a_out_valid, a_out_total, a_out_ovf);
      end
    end
    a_in_valid = 1'b0;
    drain_a();
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    send_a(8'h03, 1'b0);
    send_a(8'h04, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_total !== 12'h00A) begin
      errors++; $display("FAIL backpressure_next got valid=%b total=%h want 1 00a", a_out_valid, a_out_total);
    end
    drain_a();
  endtask

  task automatic test_reset_mid();
    send_a(8'h10, 1'b0);
    send_a(8'h20, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ready_low got %b want 0", a_in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_total !== 12'h000 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state got busy=%b ready=%b total=%h valid=%b want 0 1 000 0",
               a_busy, a_in_ready, a_out_total, a_out_valid);
    end
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    send_a(8'h03, 1'b0);
    send_a(8'h04, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_total !== 12'h00A || a_out_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_mid_total got valid=%b total=%h ovf=%b want 1 00a 0",
                         a_out_valid, a_out_total, a_out_ovf);
    end
    drain_a();
  endtask

  task automatic test_count1();
    logic [7:0]  sums [4];
    logic        cos  [4];
    logic [11:0] exp  [4];
    sums = '{8'h05, 8'hFF, 8'h80, 8'h00};
    cos  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp  = '{12'h005, 12'h1FF, 12'h080, 12'h100};
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_in_sum = sums[i]; c_in_co = cos[i];
      checks++;
      if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0) begin
        errors++; $display("FAIL count1_accept[%0d] got ready=%b valid=%b want 1 0", i, c_in_ready, c_out_valid);
      end
      tick();
      checks++;
      if (c_out_valid !== 1'b1 || c_out_total !== exp[i] || c_out_ovf !== 1'b0 || c_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL count1_total[%0d] got valid=%b total=%h ovf=%b ready=%b want 1 %h 0 0",
                 i, c_out_valid, c_out_total, c_out_ovf, c_in_ready, exp[i]);
      end
      tick();
    end
    c_in_valid = 1'b0; c_out_ready = 1'b0;
    checks++;
    if (c_out_valid !== 1'b0 || c_busy !== 1'b0) begin
      errors++; $display("FAIL count1_end got valid=%b busy=%b want 0 0", c_out_valid, c_busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_carry();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_count1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
